// File: rtl/mux_feed_serializer.sv
// Serializer that feeds a 2:1 mux: drives a bit pair plus select so the mux output is a serial stream.
// Optional build macro MUX_FEED_MSB_FIRST_EN switches the serial order from LSB-first to MSB-first.
module mux_feed_serializer #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = $clog2(WORD_W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [WORD_W-1:0] load_data,
  output logic              load_ready,
  output logic [1:0]        mux_i,
  output logic [1:0]        mux_s,
  output logic              bit_valid,
  output logic              busy,
  output logic              done
);

  localparam logic [0:0]       ST_IDLE  = 1'b0;
  localparam logic [0:0]       ST_SHIFT = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

`ifdef MUX_FEED_MSB_FIRST_EN
  // Cycle A shows the upper bit of the pair, cycle B the lower one.
  localparam logic [1:0] SEL_A = 2'b01;
  localparam logic [1:0] SEL_B = 2'b00;

  function automatic logic [1:0] head_pair(input logic [WORD_W-1:0] w);
    return w[WORD_W-1 -: 2];
  endfunction

  function automatic logic [WORD_W-1:0] drop_pair(input logic [WORD_W-1:0] w);
    return w << 2;
  endfunction
`else
  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;

  function automatic logic [1:0] head_pair(input logic [WORD_W-1:0] w);
    return w[1:0];
  endfunction

  function automatic logic [WORD_W-1:0] drop_pair(input logic [WORD_W-1:0] w);
    return w >> 2;
  endfunction
`endif

  logic [0:0]        state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        mux_i_q, mux_i_d;
  logic [1:0]        mux_s_q, mux_s_d;
  logic              bit_valid_q, bit_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              load_ready_q, load_ready_d;

  // Next-state and next-output logic; cnt_q is the index of the bit currently presented.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    mux_i_d      = mux_i_q;
    mux_s_d      = mux_s_q;
    bit_valid_d  = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    load_ready_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        mux_s_d = 2'b00;
        if (load_valid && load_ready_q) begin
          state_d      = ST_SHIFT;
          shreg_d      = drop_pair(load_data);
          mux_i_d      = head_pair(load_data);
          mux_s_d      = SEL_A;
          cnt_d        = '0;
          bit_valid_d  = 1'b1;
          busy_d       = 1'b1;
          load_ready_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          // Completion: mux_i keeps its last pair, only the select returns home.
          state_d      = ST_IDLE;
          cnt_d        = '0;
          mux_s_d      = 2'b00;
          done_d       = 1'b1;
          load_ready_d = 1'b1;
        end else begin
          cnt_d        = cnt_q + CNT_W'(1);
          bit_valid_d  = 1'b1;
          busy_d       = 1'b1;
          load_ready_d = 1'b0;
          if (cnt_q[0] == 1'b0) begin
            mux_s_d = SEL_B;
          end else begin
            mux_i_d = head_pair(shreg_q);
            shreg_d = drop_pair(shreg_q);
            mux_s_d = SEL_A;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        mux_s_d = 2'b00;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      mux_i_q      <= 2'b00;
      mux_s_q      <= 2'b00;
      bit_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      mux_i_q      <= mux_i_d;
      mux_s_q      <= mux_s_d;
      bit_valid_q  <= bit_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      load_ready_q <= load_ready_d;
    end
  end

  assign load_ready = load_ready_q;
  assign mux_i      = mux_i_q;
  assign mux_s      = mux_s_q;
  assign bit_valid  = bit_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_mux_feed_serializer.sv
// Bench for mux_feed_serializer: directed and random words checked against a bit-order reference model.
// Follows MUX_FEED_MSB_FIRST_EN the same way the design does.
module tb_mux_feed_serializer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_valid;
  logic [W-1:0] load_data;
  logic         load_ready, bit_valid, busy, done;
  logic [1:0]   mux_i, mux_s;
  logic         y;

  logic         lv2;
  logic [1:0]   ld2;
  logic         load_ready2, bit_valid2, busy2, done2;
  logic [1:0]   mux_i2, mux_s2;
  logic         y2;

  int n_assert = 0;
  int n_fail   = 0;

  mux_feed_serializer #(.WORD_W(W)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .mux_i(mux_i), .mux_s(mux_s),
    .bit_valid(bit_valid), .busy(busy), .done(done)
  );

  mux_feed_serializer #(.WORD_W(2)) dut2 (
    .clk(clk), .rst(rst), .load_valid(lv2), .load_data(ld2),
    .load_ready(load_ready2), .mux_i(mux_i2), .mux_s(mux_s2),
    .bit_valid(bit_valid2), .busy(busy2), .done(done2)
  );

  // The downstream 2:1 mux
  assign y  = mux_i[mux_s[0]];
  assign y2 = mux_i2[mux_s2[0]];

  always #5 clk = ~clk;

  // Reference model: the i-th serial bit of a word and the pair/select that present it
  function automatic logic exp_bit(input logic [W-1:0] w, input int i);
`ifdef MUX_FEED_MSB_FIRST_EN
    return w[W-1-i];
`else
    return w[i];
`endif
  endfunction

  function automatic logic [1:0] exp_i(input logic [W-1:0] w, input int i);
`ifdef MUX_FEED_MSB_FIRST_EN
    int hi = W - 1 - 2 * (i / 2);
    return {w[hi], w[hi-1]};
`else
    int lo = 2 * (i / 2);
    return {w[lo+1], w[lo]};
`endif
  endfunction

  function automatic logic [1:0] exp_s(input int i);
`ifdef MUX_FEED_MSB_FIRST_EN
    return (i % 2 == 0) ? 2'b01 : 2'b00;
`else
    return (i % 2 == 1) ? 2'b01 : 2'b00;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, " load_ready"}, 32'(load_ready), 32'd1);
    chk({tag, " busy"},       32'(busy),       32'd0);
    chk({tag, " bit_valid"},  32'(bit_valid),  32'd0);
    chk({tag, " done"},       32'(done),       32'd0);
    chk({tag, " mux_s"},      32'(mux_s),      32'd0);
  endtask

  // Present a word and wait (bounded) for it to be accepted; afterwards load_data is scrambled
  task automatic offer(input logic [W-1:0] w);
    load_data  = w;
    load_valid = 1'b1;
    for (int k = 0; k < 20 && load_ready !== 1'b1; k++) step();
    chk("offer ready timeout", 32'(load_ready), 32'd1);
    step();
    load_valid = 1'b0;
    load_data  = W'($urandom);
  endtask

  // Check nbits presented bits; with nbits == W also check the done cycle
  task automatic stream(input logic [W-1:0] w, input int nbits, input bit noise);
    for (int i = 0; i < nbits; i++) begin
      chk("shift bit_valid",  32'(bit_valid),  32'd1);
      chk("shift busy",       32'(busy),       32'd1);
      chk("shift load_ready", 32'(load_ready), 32'd0);
      chk("shift done",       32'(done),       32'd0);
      chk("shift mux_i",      32'(mux_i),      32'(exp_i(w, i)));
      chk("shift mux_s",      32'(mux_s),      32'(exp_s(i)));
      chk("shift y",          32'(y),          32'(exp_bit(w, i)));
      step();
      if (noise) begin
        load_data  = W'($urandom);
        load_valid = (i < nbits - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
    if (nbits == W) begin
      chk("end done",       32'(done),       32'd1);
      chk("end busy",       32'(busy),       32'd0);
      chk("end bit_valid",  32'(bit_valid),  32'd0);
      chk("end load_ready", 32'(load_ready), 32'd1);
      chk("end mux_s",      32'(mux_s),      32'd0);
      chk("end mux_i hold", 32'(mux_i),      32'(exp_i(w, W - 1)));
    end
  endtask

  initial begin
    logic [W-1:0] w;
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    lv2        = 1'b0;
    ld2        = 2'b00;

    // Reset, no load
    step();
    step();
    idle_chk("reset");
    chk("reset mux_i", 32'(mux_i), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      idle_chk("idle");
    end

    // Single word 8'hA5
    offer(8'hA5);
    stream(8'hA5, W, 1'b0);
    step();
    chk("a5 done pulse width", 32'(done), 32'd0);
    chk("a5 ready after",      32'(load_ready), 32'd1);

    // Load ignored while busy; the held word is taken at the end of the done cycle
    offer(8'h0F);
    load_valid = 1'b1;
    load_data  = 8'hFF;
    stream(8'h0F, W, 1'b0);
    step();
    load_valid = 1'b0;
    stream(8'hFF, W, 1'b0);
    step();

    // Mid-word reset after 3 bits
    offer(8'h3C);
    stream(8'h3C, 3, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_chk("midrst");
    chk("midrst mux_i", 32'(mux_i), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("midrst no done", 32'(done), 32'd0);
    end

    // Reset wins over a simultaneous acceptance
    load_valid = 1'b1;
    load_data  = 8'h81;
    rst        = 1'b1;
    step();
    rst = 1'b0;
    chk("rst priority busy", 32'(busy), 32'd0);
    offer(8'h81);
    stream(8'h81, W, 1'b0);
    step();

    // Random words with input noise while busy
    for (int n = 0; n < 12; n++) begin
      w = W'($urandom);
      offer(w);
      stream(w, W, 1'b1);
      step();
      chk("rand idle done", 32'(done), 32'd0);
    end

    // WORD_W = 2 instance, word 2'b10
    lv2 = 1'b1;
    ld2 = 2'b10;
    step();
    lv2 = 1'b0;
    chk("w2 valid0", 32'(bit_valid2), 32'd1);
`ifdef MUX_FEED_MSB_FIRST_EN
    chk("w2 y0", 32'(y2), 32'd1);
`else
    chk("w2 y0", 32'(y2), 32'd0);
`endif
    step();
    chk("w2 valid1", 32'(bit_valid2), 32'd1);
`ifdef MUX_FEED_MSB_FIRST_EN
    chk("w2 y1", 32'(y2), 32'd0);
`else
    chk("w2 y1", 32'(y2), 32'd1);
`endif
    step();
    chk("w2 done",   32'(done2),      32'd1);
    chk("w2 busy",   32'(busy2),      32'd0);
    chk("w2 valid2", 32'(bit_valid2), 32'd0);
    chk("w2 mux_i",  32'(mux_i2),     32'd2);
    step();
    chk("w2 done off", 32'(done2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
